// File: rtl/mem_arb_pkg.sv
// Shared owner encodings, FSM state type and small arbitration helpers for mem_bus_arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_FETCH = 2'd1;
   localparam logic [1:0] OWN_LOAD  = 2'd2;
   localparam logic [1:0] OWN_STORE = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } arb_state_e;

   // Isolates the lowest set bit; bit 0 has highest priority.
   function automatic logic [2:0] lowest_one(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

   function automatic logic [1:0] onehot_to_owner(input logic [2:0] win);
      logic [1:0] own;
      own = OWN_NONE;
      if (win[0])      own = OWN_FETCH;
      else if (win[1]) own = OWN_LOAD;
      else if (win[2]) own = OWN_STORE;
      return own;
   endfunction

   // Round-robin start index for the grant after the given winner.
   function automatic logic [1:0] next_rr_ptr(input logic [2:0] win);
      logic [1:0] ptr;
      ptr = 2'd0;
      if (win[0])      ptr = 2'd1;
      else if (win[1]) ptr = 2'd2;
      return ptr;
   endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational one-hot winner picker (bit 0 fetch, bit 1 load, bit 2 store).
// MEM_ARB_RR_EN selects round-robin from rr_ptr; otherwise fixed priority fetch > load > store.
`timescale 1ns/1ps
module mem_arb_picker
   import mem_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] rr_ptr,
   output logic [2:0] win
);

`ifdef MEM_ARB_RR_EN
   logic [2:0] rot;
   logic [2:0] pick;

   // Rotate so the start requester sits at bit 0, pick lowest, rotate back.
   always_comb begin
      case (rr_ptr)
         2'd1:    rot = {req[0], req[2], req[1]};
         2'd2:    rot = {req[1], req[0], req[2]};
         default: rot = req;
      endcase
      pick = lowest_one(rot);
      case (rr_ptr)
         2'd1:    win = {pick[1], pick[0], pick[2]};
         2'd2:    win = {pick[0], pick[2], pick[1]};
         default: win = pick;
      endcase
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^rr_ptr;

   always_comb begin
      win = lowest_one(req);
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-requester single-port memory bus arbiter with fixed wait states.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
`timescale 1ns/1ps
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              fetch_ack,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_ack,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [DATA_W-1:0] st_wdata,
   output logic              st_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        owner
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        req;
   logic [2:0]        win;
   logic [1:0]        rr_ptr;
   logic [ADDR_W-1:0] win_addr;
   logic              cnt_zero;
   logic              grant;

   assign req      = {st_req, ld_req, fetch_req};
   assign cnt_zero = (cnt_q == '0);
   assign grant    = (state_q == IDLE) && (|req);

   mem_arb_picker u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .win    (win)
   );

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   rr_ptr <= 2'd0;
      else if (grant) rr_ptr <= next_rr_ptr(win);
   end
`else
   assign rr_ptr = 2'd0;
`endif

   always_comb begin
      win_addr = fetch_addr;
      if (win[1])      win_addr = ld_addr;
      else if (win[2]) win_addr = st_addr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = ACCESS;
         ACCESS:  if (cnt_zero) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      fetch_ack = (state_q == DONE) && (owner == OWN_FETCH);
      ld_ack    = (state_q == DONE) && (owner == OWN_LOAD);
      st_ack    = (state_q == DONE) && (owner == OWN_STORE);
   end

   // Strobes are registered, so async reset drops them immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner       <= OWN_NONE;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
         cnt_q       <= '0;
         fetch_rdata <= '0;
         ld_rdata    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  owner    <= onehot_to_owner(win);
                  mem_addr <= win_addr;
                  mem_rd   <= ~win[2];
                  mem_wr   <= win[2];
                  cnt_q    <= CNT_LOAD;
                  if (win[2]) mem_wdata <= st_wdata;
               end else begin
                  owner <= OWN_NONE;
               end
            end
            ACCESS: begin
               if (cnt_zero) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (owner == OWN_FETCH) fetch_rdata <= mem_rdata;
                  if (owner == OWN_LOAD)  ld_rdata    <= mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       fetch_req, ld_req, st_req;
   logic [7:0] fetch_addr, ld_addr, st_addr, st_wdata, mem_rdata;
   logic [7:0] fetch_rdata, ld_rdata, mem_addr, mem_wdata;
   logic       fetch_ack, ld_ack, st_ack, mem_rd, mem_wr, busy;
   logic [1:0] owner;

   logic       z_ld_req;
   logic [7:0] z_ld_addr, z_mem_rdata, z_fetch_rdata, z_ld_rdata, z_mem_addr, z_mem_wdata;
   logic       z_fetch_ack, z_ld_ack, z_st_ack, z_mem_rd, z_mem_wr, z_busy;
   logic [1:0] z_owner;

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata), .fetch_ack(fetch_ack),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_rdata(ld_rdata), .ld_ack(ld_ack),
      .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_ack(st_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(1'b0), .fetch_addr(8'h00), .fetch_rdata(z_fetch_rdata), .fetch_ack(z_fetch_ack),
      .ld_req(z_ld_req), .ld_addr(z_ld_addr), .ld_rdata(z_ld_rdata), .ld_ack(z_ld_ack),
      .st_req(1'b0), .st_addr(8'h00), .st_wdata(8'h00), .st_ack(z_st_ack),
      .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr),
      .mem_rdata(z_mem_rdata), .busy(z_busy), .owner(z_owner)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int f_at, l_at, s_at, f_cnt, both;
   logic f_pend, l_pend, s_pend;

   initial begin
      reset_n = 1'b0;
      fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      fetch_addr = '0; ld_addr = '0; st_addr = '0; st_wdata = '0; mem_rdata = '0;
      z_ld_req = 1'b0; z_ld_addr = '0; z_mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_owner", owner, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_strobes", {mem_rd, mem_wr}, 0);
      check_val("rst_acks", {fetch_ack, ld_ack, st_ack}, 0);
      check_val("rst_addr", mem_addr, 0);
      check_val("rst_rdata", {fetch_rdata, ld_rdata}, 0);
      check_val("rst_z_busy", z_busy, 0);
      reset_n = 1'b1;

      // Fetch read: rdata must be the value present on the last ACCESS cycle
      fetch_addr = 8'h10; fetch_req = 1'b1; mem_rdata = 8'h5A;
      for (int k = 1; k <= 3; k++) begin
         step();
         if (k == 3) mem_rdata = 8'hA5;
         check_val("f_rd", mem_rd, 1);
         check_val("f_wr", mem_wr, 0);
         check_val("f_addr", mem_addr, 8'h10);
         check_val("f_owner", owner, 1);
         check_val("f_ack_early", fetch_ack, 0);
      end
      step();
      mem_rdata = 8'hFF;
      check_val("f_ack", fetch_ack, 1);
      check_val("f_rdata", fetch_rdata, 8'hA5);
      check_val("f_rd_done", mem_rd, 0);
      check_val("f_owner_done", owner, 1);
      check_val("f_busy_done", busy, 1);
      step();
      fetch_req = 1'b0;
      check_val("f_ack_one", fetch_ack, 0);
      check_val("f_rdata_held", fetch_rdata, 8'hA5);
      check_val("f_idle", busy, 0);

      // Store
      st_addr = 8'h20; st_wdata = 8'h3C; st_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         check_val("s_wr", mem_wr, 1);
         check_val("s_rd", mem_rd, 0);
         check_val("s_wdata", mem_wdata, 8'h3C);
         check_val("s_addr", mem_addr, 8'h20);
         check_val("s_owner", owner, 3);
      end
      step();
      check_val("s_ack", st_ack, 1);
      check_val("s_wr_done", mem_wr, 0);
      check_val("s_other_acks", {fetch_ack, ld_ack}, 0);
      step();
      st_req = 1'b0;
      check_val("s_ack_one", st_ack, 0);

      // Simultaneous requests
      fetch_addr = 8'h31; ld_addr = 8'h32; st_addr = 8'h33;
      fetch_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
      f_at = -1; l_at = -1; s_at = -1;
      f_pend = 1'b0; l_pend = 1'b0; s_pend = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (f_pend) begin fetch_req = 1'b0; f_pend = 1'b0; end
         if (l_pend) begin ld_req = 1'b0; l_pend = 1'b0; end
         if (s_pend) begin st_req = 1'b0; s_pend = 1'b0; end
         if (fetch_ack) begin if (f_at < 0) f_at = c; f_pend = 1'b1; end
         if (ld_ack)    begin if (l_at < 0) l_at = c; l_pend = 1'b1; end
         if (st_ack)    begin if (s_at < 0) s_at = c; s_pend = 1'b1; end
         if (c == 6) begin
            check_val("sim_owner_ld", owner, 2);
            check_val("sim_addr_ld", mem_addr, 8'h32);
         end
         if (c == 11) begin
            check_val("sim_owner_st", owner, 3);
            check_val("sim_addr_st", mem_addr, 8'h33);
         end
      end
      check_val("sim_fetch_at", f_at, 4);
      check_val("sim_load_at", l_at, 9);
      check_val("sim_store_at", s_at, 14);

      // Fetch re-requesting every IDLE while load is held
      fetch_addr = 8'h40; ld_addr = 8'h41;
      fetch_req = 1'b1; ld_req = 1'b1;
      l_at = -1; l_pend = 1'b0; f_cnt = 0; both = 0;
      for (int c = 1; c <= 50; c++) begin
         step();
         if (l_pend) begin ld_req = 1'b0; l_pend = 1'b0; end
         if (ld_ack) begin if (l_at < 0) l_at = c; l_pend = 1'b1; end
         if (fetch_ack) f_cnt++;
         if (mem_rd && mem_wr) both++;
      end
      fetch_req = 1'b0; ld_req = 1'b0;
`ifdef MEM_ARB_RR_EN
      check_val("starve_load_at", l_at, 9);
      check_val("starve_fetch_cnt", f_cnt, 9);
`else
      check_val("starve_load_at", l_at, -1);
      check_val("starve_fetch_cnt", f_cnt, 10);
`endif
      check_val("strobe_exclusive", both, 0);
      repeat (6) step();
      check_val("drain_idle", busy, 0);

      // Reset mid-access of a load
      ld_addr = 8'h44; ld_req = 1'b1;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst_mid_rd", mem_rd, 0);
      check_val("rst_mid_busy", busy, 0);
      check_val("rst_mid_owner", owner, 0);
      check_val("rst_mid_ack", ld_ack, 0);
      ld_req = 1'b0;
      step();
      step();
      check_val("rst_hold_ack", ld_ack, 0);
      reset_n = 1'b1;
      step();
      step();
      check_val("rst_rel_idle", {busy, ld_ack}, 0);
      ld_addr = 8'h46; ld_req = 1'b1; mem_rdata = 8'h77;
      for (int k = 1; k <= 3; k++) begin
         step();
         check_val("rst_new_rd", mem_rd, 1);
         check_val("rst_new_addr", mem_addr, 8'h46);
         check_val("rst_new_owner", owner, 2);
      end
      step();
      check_val("rst_new_ack", ld_ack, 1);
      check_val("rst_new_rdata", ld_rdata, 8'h77);
      step();
      ld_req = 1'b0;
      check_val("rst_new_ack_one", ld_ack, 0);

      // Zero wait states
      z_ld_addr = 8'h05; z_mem_rdata = 8'h99; z_ld_req = 1'b1;
      step();
      check_val("z_rd", z_mem_rd, 1);
      check_val("z_addr", z_mem_addr, 8'h05);
      check_val("z_ack_early", z_ld_ack, 0);
      check_val("z_busy", z_busy, 1);
      step();
      check_val("z_ack", z_ld_ack, 1);
      check_val("z_rd_done", z_mem_rd, 0);
      check_val("z_rdata", z_ld_rdata, 8'h99);
      step();
      z_ld_req = 1'b0;
      check_val("z_ack_one", z_ld_ack, 0);
      check_val("z_idle", z_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
